hls_perf_monitor: RTL and testbench
===================================

Name: hls_perf_monitor

Overview:
- Synthesisable, multi-channel successor to the cosim dataflow/module status monitor. Watches NUM_CH ap_ctrl_chain handshake groups, one per HLS kernel or sub-function.
- Per channel it accumulates: transaction count, start-to-done latency (last/min/max), start-to-start interval, back-pressure stall cycles and loop-iteration count.
- Sits beside the kernel in the test harness or on-chip debug. Statistics are read through a registered channel-select readout port.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16).
- CNT_W, 32, width of every statistic counter; all counters saturate.
- CH_W, $clog2(NUM_CH) min 1, width of the readout channel select.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- ap_start  in  NUM_CH  per-channel kernel ap_start.
- ap_ready  in  NUM_CH  per-channel kernel ap_ready.
- ap_done  in  NUM_CH  per-channel kernel ap_done.
- ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 for ap_ctrl_hs).
- iter_pulse  in  NUM_CH  one-cycle pulse per loop-iteration end (FSM iter_end_state decode).
- finish  in  1  freeze: while high, no counter updates.
- clear  in  1  synchronous soft clear of all statistics; FSMs are not reset.
- rd_req  in  1  readout request.
- rd_ch  in  CH_W  channel to read.
- rd_valid  out  1  pulses one cycle after rd_req.
- rd_txn, rd_lat_last, rd_lat_min, rd_lat_max, rd_interval, rd_stall, rd_iter  out  CNT_W each  statistics of the selected channel.
- busy  out  NUM_CH  per-channel transaction-in-flight flag.
- overlap_err  out  NUM_CH  sticky flag: a second start was accepted before done.

Behaviour:
- Reset: all counters 0, lat_min = all-ones, FSMs IDLE, rd_valid 0, all rd_* 0, busy 0, overlap_err 0.
- Per-channel FSM:
  - IDLE -> RUN on ap_start=1 (start cycle = cycle 0; lat_cnt <= 1).
  - RUN -> DONE_WAIT on ap_done=1 with ap_continue=0.
  - RUN -> IDLE on ap_done&ap_continue.
  - DONE_WAIT -> IDLE on ap_continue=1.
  - busy = (state != IDLE).
- Latency: cycles from the start cycle to the cycle ap_done is first seen, inclusive. A start and done in the same cycle gives latency 1 and the state stays IDLE.
- On done (first ap_done cycle of a transaction):
  - txn += 1.
  - lat_last <= lat.
  - lat_min and lat_max updated, comparisons taken against pre-update values.
- Stall: +1 for each cycle in DONE_WAIT, and for each cycle with ap_start=1 & ap_ready=0 while in RUN.
- Interval: cycles between consecutive accepted starts (ap_start & state IDLE, or ap_start & ap_ready in RUN). Stored as interval_last; the first start after reset/clear stores 0.
- Overlap: ap_start & ap_ready in RUN before done sets overlap_err. Latency continues to measure the oldest transaction.
- iter_pulse: iter += 1, regardless of FSM state.
- Saturation: every counter holds at 2^CNT_W-1 and never wraps.
- finish=1: all counters and lat tracking hold; FSMs keep tracking. Clearing finish resumes counting.
- clear=1: statistics and overlap_err reset as at reset; FSM state and busy are kept; an in-flight lat_cnt restarts from 1. If clear and an event occur in the same cycle, clear wins.
- Readout:
  - rd_req in cycle N -> rd_valid=1 and rd_* in cycle N+1, holding until the next rd_req.
  - rd_ch >= NUM_CH returns all zeros with rd_valid=1.
  - Readout shows values registered at cycle N, excluding same-cycle updates.
- Reset mid-transaction: FSM to IDLE immediately; the partial transaction is discarded.

Decomposition:
- Package hls_perf_pkg:
  - ch_state_e {IDLE, RUN, DONE_WAIT}.
  - ch_stats_t struct (txn, lat_last, lat_min, lat_max, interval, stall, iter), parametrised via CNT_W localparam default.
  - Saturating-increment function.
- Sub-module hls_perf_monitor_ch: one channel's FSM plus counters, instantiated NUM_CH times by generate. The top level holds the readout mux and registers.

Test Plan:
- Single transaction ch0: start@c10, done@c17, continue=1 -> txn=1, lat_last=lat_min=lat_max=8, stall=0, busy low from c18.
- Back-pressure ch1: done@c20 with continue low until c24 -> stall=4, FSM IDLE at c25, lat measured to c20.
- Three transactions ch2 with latencies 5, 12, 7 and starts 20 cycles apart -> lat_min=5, lat_max=12, lat_last=7, interval=20, txn=3.
- Overlap ch3: start&ready again in RUN before done -> overlap_err[3]=1 sticky; cleared only by clear/reset.
- CNT_W=4, 20 iter_pulses on ch0 -> rd_iter=15. finish=1 then 3 more pulses -> still 15.
- Reset asserted mid-RUN on ch0, then rd_req rd_ch=0 -> rd_valid next cycle, all stats 0, lat_min=all-ones; rd_ch=NUM_CH -> zeros.

Source files
------------

// File: rtl/hls_perf_pkg.sv
// Shared types and helpers for the HLS handshake performance monitor.
package hls_perf_pkg;

    // Storage width of every statistic; a monitor instance uses CNT_W <= StatW bits of it.
    localparam int unsigned StatW = 32;

    typedef logic [StatW-1:0] stat_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDoneWait
    } ch_state_e;

    typedef struct packed {
        stat_t txn;
        stat_t lat_last;
        stat_t lat_min;
        stat_t lat_max;
        stat_t interval;
        stat_t stall;
        stat_t iter;
    } ch_stats_t;

    // Increment that holds at max_val instead of wrapping.
    function automatic stat_t sat_inc(input stat_t val, input stat_t max_val);
        return (val >= max_val) ? max_val : val + stat_t'(1);
    endfunction

    // Statistics as they look after reset or a soft clear.
    function automatic ch_stats_t stats_init(input stat_t max_val);
        ch_stats_t s;
        s         = '0;
        s.lat_min = max_val;
        return s;
    endfunction

endpackage

// File: rtl/hls_perf_monitor_ch.sv
// One ap_ctrl_chain channel: handshake tracker plus saturating statistics.
module hls_perf_monitor_ch
    import hls_perf_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      ap_start_i,
    input  logic      ap_ready_i,
    input  logic      ap_done_i,
    input  logic      ap_continue_i,
    input  logic      iter_pulse_i,
    input  logic      finish_i,
    input  logic      clear_i,
    output ch_stats_t stats_o,
    output logic      busy_o,
    output logic      overlap_err_o
);

    // Counters live in StatW-bit fields but never exceed the CNT_W-bit ceiling.
    localparam stat_t SatMax = stat_t'({CNT_W{1'b1}});

    ch_state_e state_q, state_d;
    ch_stats_t stats_q, stats_d;
    stat_t     lat_cnt_q, lat_cnt_d;
    stat_t     since_q, since_d;
    logic      seen_q, seen_d;
    logic      overlap_q, overlap_d;

    logic  in_idle, in_run, in_wait;
    logic  acc_start, done_evt, stall_evt, overlap_evt;
    stat_t lat_now;

    // Event decode from the current state and handshake inputs.
    always_comb begin
        in_idle     = (state_q == StIdle);
        in_run      = (state_q == StRun);
        in_wait     = (state_q == StDoneWait);
        acc_start   = ap_start_i && (in_idle || (in_run && ap_ready_i));
        // A start with a same-cycle done counts as a one-cycle transaction.
        done_evt    = ap_done_i && (in_run || (in_idle && ap_start_i));
        stall_evt   = in_wait || (in_run && ap_start_i && !ap_ready_i);
        overlap_evt = in_run && ap_start_i && ap_ready_i && !ap_done_i;
        lat_now     = in_idle ? stat_t'(1) : sat_inc(lat_cnt_q, SatMax);
    end

    // Handshake FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ap_start_i && !ap_done_i) state_d = StRun;
            end
            StRun: begin
                if (ap_done_i) state_d = ap_continue_i ? StIdle : StDoneWait;
            end
            StDoneWait: begin
                if (ap_continue_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Statistics next state: clear beats everything, finish freezes counting.
    always_comb begin
        stats_d   = stats_q;
        lat_cnt_d = lat_cnt_q;
        since_d   = since_q;
        seen_d    = seen_q;
        overlap_d = overlap_q;

        if (clear_i) begin
            stats_d   = stats_init(SatMax);
            lat_cnt_d = stat_t'(1);
            since_d   = '0;
            seen_d    = 1'b0;
            overlap_d = 1'b0;
        end else begin
            // Overlap is a protocol flag, not a counter, so finish does not mask it.
            if (overlap_evt) overlap_d = 1'b1;

            if (!finish_i) begin
                if (iter_pulse_i) stats_d.iter = sat_inc(stats_q.iter, SatMax);
                if (stall_evt) stats_d.stall = sat_inc(stats_q.stall, SatMax);

                if (done_evt) begin
                    stats_d.txn      = sat_inc(stats_q.txn, SatMax);
                    stats_d.lat_last = lat_now;
                    if (lat_now < stats_q.lat_min) stats_d.lat_min = lat_now;
                    if (lat_now > stats_q.lat_max) stats_d.lat_max = lat_now;
                end

                // Overlapped starts do not restart lat_cnt: it tracks the oldest transaction.
                if (in_idle && ap_start_i) begin
                    lat_cnt_d = stat_t'(1);
                end else if (in_run) begin
                    lat_cnt_d = sat_inc(lat_cnt_q, SatMax);
                end

                if (acc_start) begin
                    stats_d.interval = seen_q ? since_q : '0;
                    since_d          = stat_t'(1);
                    seen_d           = 1'b1;
                end else if (seen_q) begin
                    since_d = sat_inc(since_q, SatMax);
                end
            end
        end
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            stats_q   <= stats_init(SatMax);
            lat_cnt_q <= '0;
            since_q   <= '0;
            seen_q    <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stats_q   <= stats_d;
            lat_cnt_q <= lat_cnt_d;
            since_q   <= since_d;
            seen_q    <= seen_d;
            overlap_q <= overlap_d;
        end
    end

    assign stats_o       = stats_q;
    assign busy_o        = (state_q != StIdle);
    assign overlap_err_o = overlap_q;

endmodule

// File: rtl/hls_perf_monitor.sv
// Multi-channel HLS handshake performance monitor with registered readout port.
module hls_perf_monitor
    import hls_perf_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] ap_start_i,
    input  logic [NUM_CH-1:0] ap_ready_i,
    input  logic [NUM_CH-1:0] ap_done_i,
    input  logic [NUM_CH-1:0] ap_continue_i,
    input  logic [NUM_CH-1:0] iter_pulse_i,
    input  logic              finish_i,
    input  logic              clear_i,
    input  logic              rd_req_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_txn_o,
    output logic [CNT_W-1:0]  rd_lat_last_o,
    output logic [CNT_W-1:0]  rd_lat_min_o,
    output logic [CNT_W-1:0]  rd_lat_max_o,
    output logic [CNT_W-1:0]  rd_interval_o,
    output logic [CNT_W-1:0]  rd_stall_o,
    output logic [CNT_W-1:0]  rd_iter_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] overlap_err_o
);

    ch_stats_t stats [NUM_CH];
    ch_stats_t rd_sel;
    ch_stats_t rd_q;
    logic      rd_valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hls_perf_monitor_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clock_i      (clock_i),
            .reset_i      (reset_i),
            .ap_start_i   (ap_start_i[g]),
            .ap_ready_i   (ap_ready_i[g]),
            .ap_done_i    (ap_done_i[g]),
            .ap_continue_i(ap_continue_i[g]),
            .iter_pulse_i (iter_pulse_i[g]),
            .finish_i     (finish_i),
            .clear_i      (clear_i),
            .stats_o      (stats[g]),
            .busy_o       (busy_o[g]),
            .overlap_err_o(overlap_err_o[g])
        );
    end

    // Channel select; unpopulated channel numbers read back as zero.
    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rd_ch_i == CH_W'(i)) rd_sel = stats[i];
        end
    end

    // Readout register: captures the pre-update statistics on each request and holds.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) rd_q <= rd_sel;
        end
    end

    assign rd_valid_o    = rd_valid_q;
    assign rd_txn_o      = rd_q.txn[CNT_W-1:0];
    assign rd_lat_last_o = rd_q.lat_last[CNT_W-1:0];
    assign rd_lat_min_o  = rd_q.lat_min[CNT_W-1:0];
    assign rd_lat_max_o  = rd_q.lat_max[CNT_W-1:0];
    assign rd_interval_o = rd_q.interval[CNT_W-1:0];
    assign rd_stall_o    = rd_q.stall[CNT_W-1:0];
    assign rd_iter_o     = rd_q.iter[CNT_W-1:0];

endmodule

// File: tb/tb_hls_perf_monitor.sv
// Self-checking bench: transaction-level reference model plus directed literal checks.
module tb_hls_perf_monitor;

    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int CHW = 3;
    localparam int M   = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_cont, iter;
    logic           finish, clr, rd_req;
    logic [CHW-1:0] rd_ch;
    logic           rd_valid;
    logic [CW-1:0]  rd_txn, rd_last, rd_min, rd_max, rd_int, rd_stall, rd_iter;
    logic [NCH-1:0] busy, ovl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hls_perf_monitor #(
        .NUM_CH(NCH),
        .CNT_W (CW),
        .CH_W  (CHW)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .ap_start_i   (ap_start),
        .ap_ready_i   (ap_ready),
        .ap_done_i    (ap_done),
        .ap_continue_i(ap_cont),
        .iter_pulse_i (iter),
        .finish_i     (finish),
        .clear_i      (clr),
        .rd_req_i     (rd_req),
        .rd_ch_i      (rd_ch),
        .rd_valid_o   (rd_valid),
        .rd_txn_o     (rd_txn),
        .rd_lat_last_o(rd_last),
        .rd_lat_min_o (rd_min),
        .rd_lat_max_o (rd_max),
        .rd_interval_o(rd_int),
        .rd_stall_o   (rd_stall),
        .rd_iter_o    (rd_iter),
        .busy_o       (busy),
        .overlap_err_o(ovl)
    );

    // Reference model: timestamps in unfrozen ticks, per-channel transaction flags.
    int m_txn [NCH], m_last [NCH], m_min [NCH], m_max [NCH];
    int m_int [NCH], m_stall [NCH], m_iter [NCH], m_t0 [NCH], m_tl [NCH];
    bit m_infl [NCH], m_wait [NCH], m_ovl [NCH], m_have [NCH];
    int t;
    bit started = 1'b0;
    bit e_valid;
    int e_rd [7];

    function automatic int sat(input int v);
        return (v > M) ? M : v;
    endfunction

    task automatic clear_stats(input int c);
        m_txn[c] = 0; m_last[c] = 0; m_min[c] = M; m_max[c] = 0;
        m_int[c] = 0; m_stall[c] = 0; m_iter[c] = 0; m_have[c] = 0; m_ovl[c] = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            t       = 0;
            e_valid = 1'b0;
            for (int i = 0; i < 7; i++) e_rd[i] = 0;
            for (int c = 0; c < NCH; c++) begin
                clear_stats(c);
                m_infl[c] = 0; m_wait[c] = 0; m_t0[c] = 0; m_tl[c] = 0;
            end
        end else if (started) begin
            e_valid = rd_req;
            if (rd_req) begin
                if (int'(rd_ch) < NCH) begin
                    e_rd[0] = m_txn[rd_ch];  e_rd[1] = m_last[rd_ch]; e_rd[2] = m_min[rd_ch];
                    e_rd[3] = m_max[rd_ch];  e_rd[4] = m_int[rd_ch];  e_rd[5] = m_stall[rd_ch];
                    e_rd[6] = m_iter[rd_ch];
                end else begin
                    for (int i = 0; i < 7; i++) e_rd[i] = 0;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                bit s, r, d, k, idle, run, acc, dn, stl, ov;
                int lat;
                s = ap_start[c]; r = ap_ready[c]; d = ap_done[c]; k = ap_cont[c];
                idle = !m_infl[c];
                run  = m_infl[c] && !m_wait[c];
                acc  = s && (idle || (run && r));
                dn   = d && (run || (idle && s));
                stl  = m_wait[c] || (run && s && !r);
                ov   = run && s && r && !d;
                lat  = idle ? 1 : sat(t - m_t0[c] + 1);
                if (clr) begin
                    clear_stats(c);
                end else begin
                    if (ov) m_ovl[c] = 1;
                    if (!finish) begin
                        if (iter[c]) m_iter[c] = sat(m_iter[c] + 1);
                        if (stl) m_stall[c] = sat(m_stall[c] + 1);
                        if (dn) begin
                            m_txn[c]  = sat(m_txn[c] + 1);
                            m_last[c] = lat;
                            if (lat < m_min[c]) m_min[c] = lat;
                            if (lat > m_max[c]) m_max[c] = lat;
                        end
                        if (acc) begin
                            m_int[c]  = m_have[c] ? sat(t - m_tl[c]) : 0;
                            m_tl[c]   = t;
                            m_have[c] = 1;
                        end
                    end
                end
                if (idle && s && !d) begin
                    m_infl[c] = 1;
                    m_t0[c]   = t;
                end else if (run && d) begin
                    if (k) m_infl[c] = 0;
                    else m_wait[c] = 1;
                end else if (m_wait[c] && k) begin
                    m_infl[c] = 0;
                    m_wait[c] = 0;
                end
                if (clr) m_t0[c] = t;
            end
            if (!finish) t++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (started) begin
            logic [NCH-1:0] eb, eo;
            for (int c = 0; c < NCH; c++) begin
                eb[c] = m_infl[c];
                eo[c] = m_ovl[c];
            end
            chk("busy", 64'(busy), 64'(eb));
            chk("overlap_err", 64'(ovl), 64'(eo));
            chk("rd_valid", 64'(rd_valid), 64'(e_valid));
            chk("rd_txn", 64'(rd_txn), 64'(e_rd[0]));
            chk("rd_lat_last", 64'(rd_last), 64'(e_rd[1]));
            chk("rd_lat_min", 64'(rd_min), 64'(e_rd[2]));
            chk("rd_lat_max", 64'(rd_max), 64'(e_rd[3]));
            chk("rd_interval", 64'(rd_int), 64'(e_rd[4]));
            chk("rd_stall", 64'(rd_stall), 64'(e_rd[5]));
            chk("rd_iter", 64'(rd_iter), 64'(e_rd[6]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic readout(input int ch);
        rd_req = 1'b1;
        rd_ch  = CHW'(ch);
        step();
        rd_req = 1'b0;
    endtask

    task automatic run_txn(input int ch, input int lat);
        ap_start[ch] = 1'b1;
        step();
        ap_start[ch] = 1'b0;
        repeat (lat - 2) step();
        ap_done[ch] = 1'b1;
        step();
        ap_done[ch] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; finish = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_ch = '0;
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_cont = '1; iter = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("lit_reset_valid", 64'(rd_valid), 64'd0);
        readout(0);
        chk("lit_reset_min", 64'(rd_min), 64'(M));
        chk("lit_reset_txn", 64'(rd_txn), 64'd0);

        // Single transaction, latency 8.
        run_txn(0, 8);
        chk("lit_t1_busy", 64'(busy[0]), 64'd0);
        readout(0);
        chk("lit_t1_txn", 64'(rd_txn), 64'd1);
        chk("lit_t1_last", 64'(rd_last), 64'd8);
        chk("lit_t1_min", 64'(rd_min), 64'd8);
        chk("lit_t1_max", 64'(rd_max), 64'd8);
        chk("lit_t1_stall", 64'(rd_stall), 64'd0);

        // Back-pressure: continue low for four cycles after done.
        ap_cont[1] = 1'b0;
        ap_start[1] = 1'b1;
        step();
        ap_start[1] = 1'b0;
        repeat (4) step();
        ap_done[1] = 1'b1;
        step();
        ap_done[1] = 1'b0;
        repeat (3) step();
        chk("lit_t2_busy_wait", 64'(busy[1]), 64'd1);
        ap_cont[1] = 1'b1;
        step();
        chk("lit_t2_idle", 64'(busy[1]), 64'd0);
        readout(1);
        chk("lit_t2_stall", 64'(rd_stall), 64'd4);
        chk("lit_t2_last", 64'(rd_last), 64'd6);

        // Three transactions twenty cycles apart.
        run_txn(2, 5);
        repeat (15) step();
        run_txn(2, 12);
        repeat (8) step();
        run_txn(2, 7);
        readout(2);
        chk("lit_t3_txn", 64'(rd_txn), 64'd3);
        chk("lit_t3_min", 64'(rd_min), 64'd5);
        chk("lit_t3_max", 64'(rd_max), 64'd12);
        chk("lit_t3_last", 64'(rd_last), 64'd7);
        chk("lit_t3_interval", 64'(rd_int), 64'd20);

        // Overlapped start on channel 3.
        ap_start[3] = 1'b1;
        step();
        ap_start[3] = 1'b0;
        step();
        step();
        ap_start[3] = 1'b1;
        ap_ready[3] = 1'b1;
        step();
        ap_start[3] = 1'b0;
        ap_ready[3] = 1'b0;
        step();
        chk("lit_t4_ovl", 64'(ovl[3]), 64'd1);
        ap_done[3] = 1'b1;
        step();
        ap_done[3] = 1'b0;
        repeat (3) step();
        chk("lit_t4_sticky", 64'(ovl[3]), 64'd1);
        readout(3);
        chk("lit_t4_last", 64'(rd_last), 64'd6);
        chk("lit_t4_interval", 64'(rd_int), 64'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("lit_t4_cleared", 64'(ovl[3]), 64'd0);

        // Iteration counter saturation and finish freeze.
        iter[0] = 1'b1;
        repeat (M + 5) step();
        iter[0] = 1'b0;
        readout(0);
        chk("lit_t5_sat", 64'(rd_iter), 64'(M));
        clr = 1'b1;
        step();
        clr = 1'b0;
        finish = 1'b1;
        iter[0] = 1'b1;
        repeat (3) step();
        iter[0] = 1'b0;
        finish = 1'b0;
        readout(0);
        chk("lit_t5_frozen", 64'(rd_iter), 64'd0);
        iter[0] = 1'b1;
        repeat (2) step();
        iter[0] = 1'b0;
        readout(0);
        chk("lit_t5_resume", 64'(rd_iter), 64'd2);

        // Reset in the middle of a transaction.
        ap_start[0] = 1'b1;
        step();
        ap_start[0] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_t6_busy", 64'(busy[0]), 64'd0);
        readout(0);
        chk("lit_t6_valid", 64'(rd_valid), 64'd1);
        chk("lit_t6_txn", 64'(rd_txn), 64'd0);
        chk("lit_t6_min", 64'(rd_min), 64'(M));
        readout(NCH);
        chk("lit_t6_oob_valid", 64'(rd_valid), 64'd1);
        chk("lit_t6_oob_min", 64'(rd_min), 64'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ap_start[c] = ($urandom_range(0, 3) == 0);
                ap_ready[c] = $urandom_range(0, 1) != 0;
                ap_done[c]  = ($urandom_range(0, 5) == 0);
                ap_cont[c]  = ($urandom_range(0, 3) != 0);
                iter[c]     = ($urandom_range(0, 3) == 0);
            end
            clr    = ($urandom_range(0, 150) == 0);
            rst    = ($urandom_range(0, 999) == 0);
            rd_req = ($urandom_range(0, 2) == 0);
            rd_ch  = CHW'($urandom_range(0, 7));
            step();
        end
        ap_start = '0; ap_done = '0; iter = '0; clr = 1'b0; rst = 1'b0; rd_req = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
